snd_conditioner: RTL and testbench

Audio post-processor for the 11-bit volume-scaled sample stream produced by the data controller (`audioOut`, refreshed once per sound-buffer fetch). It removes the DC offset inherent in the unsigned Mac sound samples, smooths the stair-step output with a single-pole low-pass, and presents signed 16-bit PCM to the platform audio mixer. An optional first-order sigma-delta modulator provides a 1-bit output for pin-level DACs.

---
 rtl/snd_conditioner_if.sv | 20 ++
 rtl/snd_conditioner.sv | 111 +++++++++++
 tb/tb_snd_conditioner.sv | 131 +++++++++++++
 3 files changed

// File: rtl/snd_conditioner_if.sv
// Sample stream in / conditioned audio out bundle for snd_conditioner.
// master = upstream sample source and audio sink; slave = the conditioner.
interface snd_conditioner_if;
  logic               cep;
  logic        [10:0] audio_in;
  logic               sample_valid;
  logic signed [15:0] pcm;
  logic               idle;
  logic               sdm_out;

  modport master (
    output cep, audio_in, sample_valid,
    input  pcm, idle, sdm_out
  );

  modport slave (
    input  cep, audio_in, sample_valid,
    output pcm, idle, sdm_out
  );
endinterface

// File: rtl/snd_conditioner.sv
// DC blocker + one-pole low-pass turning 11-bit unsigned Mac audio into signed 16-bit PCM.
// Define SND_CONDITIONER_SDM_EN to add a first-order sigma-delta 1-bit output on sdm_out.
module snd_conditioner #(
  parameter int HP_SHIFT  = 10,
  parameter int LP_SHIFT  = 3,
  parameter int IDLE_BITS = 16
) (
  input logic               clk,
  input logic               _reset,
  snd_conditioner_if.slave  bus
);

  localparam logic [IDLE_BITS-1:0] CNT_MAX = '1;

  logic               [15:0] xIn;
  logic                      sampleEvt;
  logic               [15:0] xPrev_p0;
  logic signed        [15:0] hp_p0;
  logic signed        [15:0] lp_p1;
  logic                      first;
  logic                      idleReg;
  logic      [IDLE_BITS-1:0] idleCnt;

  logic signed        [16:0] dDiff;
  logic signed        [15:0] hpDecay;
  logic signed        [17:0] hpSum;
  logic signed        [15:0] hpNext;
  logic signed        [15:0] lpNext;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'sh7FFF;
    else if (v < -18'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  // lp stays inside the 16-bit range, so dropping the top bit of the sum is exact
  function automatic logic signed [15:0] lpStep(input logic signed [15:0] hp,
                                                input logic signed [15:0] lp);
    logic signed [16:0] diff;
    logic signed [16:0] sum;
    diff = 17'(hp) - 17'(lp);
    sum  = 17'(lp) + (diff >>> LP_SHIFT);
    return 16'(sum);
  endfunction

  assign xIn       = {1'b0, bus.audio_in, 4'b0};
  assign sampleEvt = bus.sample_valid & bus.cep;

  // Stage p0: DC blocker on each accepted sample
  assign dDiff   = $signed({1'b0, xIn}) - $signed({1'b0, xPrev_p0});
  assign hpDecay = hp_p0 >>> HP_SHIFT;
  assign hpSum   = 18'(hp_p0) + 18'(dDiff) - 18'(hpDecay);
  assign hpNext  = sat16(hpSum);

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      xPrev_p0 <= '0;
      hp_p0    <= '0;
      first    <= 1'b1;
      idleReg  <= 1'b1;
      idleCnt  <= '0;
    end else if (sampleEvt) begin
      // A primed sample only records the level, so startup/resume does not click
      xPrev_p0 <= xIn;
      if (!first) hp_p0 <= hpNext;
      first    <= 1'b0;
      idleReg  <= 1'b0;
      idleCnt  <= '0;
    end else if (bus.cep && idleCnt != CNT_MAX) begin
      idleCnt <= idleCnt + 1'b1;
      if (idleCnt == CNT_MAX - 1'b1) begin
        idleReg <= 1'b1;
        first   <= 1'b1;
      end
    end
  end

  // Stage p1: smoothing low-pass, sees hp from the previous edge
  assign lpNext = lpStep(hp_p0, lp_p1);

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset)      lp_p1 <= '0;
    else if (bus.cep) lp_p1 <= lpNext;
  end

  assign bus.pcm  = lp_p1;
  assign bus.idle = idleReg;

`ifdef SND_CONDITIONER_SDM_EN
  logic [15:0] sdmAcc;
  logic [16:0] sdmSum;
  logic        sdmBit;

  assign sdmSum = {1'b0, sdmAcc} + {1'b0, ~lp_p1[15], lp_p1[14:0]};

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      sdmAcc <= '0;
      sdmBit <= 1'b0;
    end else begin
      sdmAcc <= sdmSum[15:0];
      sdmBit <= sdmSum[16];
    end
  end

  assign bus.sdm_out = sdmBit;
`else
  assign bus.sdm_out = 1'b0;
`endif

endmodule

// File: tb/tb_snd_conditioner.sv
// Directed bench for snd_conditioner with a short idle timeout (IDLE_BITS=4).
module tb_snd_conditioner;
  logic clk = 1'b0;
  logic rstN;
  int   nErr = 0;
  int   nChecks = 0;

  snd_conditioner_if bus();

  snd_conditioner #(.HP_SHIFT(10), .LP_SHIFT(3), .IDLE_BITS(4)) dut (
    .clk    (clk),
    ._reset (rstN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // drive at a falling edge, let one rising edge pass, return at the next falling edge
  task automatic step(input logic c, input logic v, input logic [10:0] a);
    bus.cep          = c;
    bus.sample_valid = v;
    bus.audio_in     = a;
    @(negedge clk);
  endtask

  initial begin
    int ones;
    bus.cep = 1'b0;
    bus.sample_valid = 1'b0;
    bus.audio_in = '0;
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pcm", 32'(bus.pcm), 0);
    chk("reset_idle", 32'(bus.idle), 1);
    chk("reset_sdm", 32'(bus.sdm_out), 0);
    rstN = 1'b1;

`ifdef SND_CONDITIONER_SDM_EN
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b0, 11'd0);
      ones += int'(bus.sdm_out);
    end
    chk("sdm_half_density", 32'(ones), 32);
`else
    ones = 0;
`endif

    repeat (3) step(1'b1, 1'b0, 11'd0);
    chk("idle_pcm_zero", 32'(bus.pcm), 0);

    // priming then a step
    step(1'b1, 1'b1, 11'h100);
    chk("prime_hp", 32'(dut.hp_p0), 0);
    chk("prime_xprev", 32'(dut.xPrev_p0), 32'h1000);
    chk("prime_idle", 32'(bus.idle), 0);
    step(1'b1, 1'b1, 11'h200);
    chk("step_hp", 32'(dut.hp_p0), 4096);
    chk("step_pcm_old_hp", 32'(bus.pcm), 0);
    step(1'b1, 1'b0, 11'd0);
    chk("lp_tick1", 32'(bus.pcm), 512);
    step(1'b1, 1'b0, 11'd0);
    chk("lp_tick2", 32'(bus.pcm), 960);
    step(1'b1, 1'b0, 11'd0);
    chk("lp_tick3", 32'(bus.pcm), 1352);
`ifndef SND_CONDITIONER_SDM_EN
    chk("sdm_tied_low", 32'(bus.sdm_out), 0);
`endif

    // strobe without cep is ignored
    step(1'b0, 1'b1, 11'h7FF);
    chk("nocep_hp", 32'(dut.hp_p0), 4096);
    chk("nocep_xprev", 32'(dut.xPrev_p0), 32'h2000);
    chk("nocep_pcm", 32'(bus.pcm), 1352);

    // asynchronous reset mid-stream
    rstN = 1'b0;
    #1;
    chk("midreset_pcm", 32'(bus.pcm), 0);
    chk("midreset_idle", 32'(bus.idle), 1);
    @(negedge clk);
    rstN = 1'b1;

    // DC decay from a full-scale prime
    step(1'b1, 1'b1, 11'h7FF);
    chk("dc_prime_hp", 32'(dut.hp_p0), 0);
    step(1'b1, 1'b1, 11'd0);
    chk("dc_hp1", 32'(dut.hp_p0), -32752);
    step(1'b1, 1'b1, 11'd0);
    chk("dc_hp2", 32'(dut.hp_p0), -32720);
    chk("dc_pcm2", 32'(bus.pcm), -4094);
    step(1'b1, 1'b1, 11'd0);
    chk("dc_hp3", 32'(dut.hp_p0), -32688);
    chk("dc_pcm3", 32'(bus.pcm), -7673);

    // idle timeout and re-prime
    repeat (14) step(1'b1, 1'b0, 11'd0);
    chk("idle_before_tc", 32'(bus.idle), 0);
    step(1'b1, 1'b0, 11'd0);
    chk("idle_at_tc", 32'(bus.idle), 1);
    step(1'b1, 1'b1, 11'h3FF);
    chk("reprime_hp", 32'(dut.hp_p0), -32688);
    chk("reprime_xprev", 32'(dut.xPrev_p0), 32'h3FF0);
    chk("reprime_idle", 32'(bus.idle), 0);
    step(1'b1, 1'b1, 11'h3FF);
    chk("after_reprime_hp", 32'(dut.hp_p0), -32656);

    // sample on the terminal-count edge wins
    repeat (14) step(1'b1, 1'b0, 11'd0);
    chk("coinc_pre_idle", 32'(bus.idle), 0);
    step(1'b1, 1'b1, 11'h3FF);
    chk("coinc_idle", 32'(bus.idle), 0);
    chk("coinc_cnt", 32'(dut.idleCnt), 0);
    chk("coinc_hp", 32'(dut.hp_p0), -32624);
    repeat (14) step(1'b1, 1'b0, 11'd0);
    chk("coinc_post_idle", 32'(bus.idle), 0);
    step(1'b1, 1'b0, 11'd0);
    chk("coinc_final_idle", 32'(bus.idle), 1);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end
endmodule
